// File: rtl/rm_symbol_feeder.sv
// rm_symbol_feeder: buffers multi-lane trace symbols and streams them one per cycle to the monitor clusters.
module rm_symbol_feeder #(
    parameter int SYM_W      = 8,
    parameter int NUM_EVT    = 2,
    parameter int DEPTH      = 8,
    parameter int RST_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_EVT-1:0]         evt_valid,
    input  logic [NUM_EVT*SYM_W-1:0]   evt_sym,
    output logic                       evt_ready,
    input  logic                       enable,
    input  logic                       flush,
    output logic [SYM_W-1:0]           symbols,
    output logic                       run,
    output logic                       mon_reset,
    output logic                       overflow,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);
    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = $clog2(DEPTH+1);
    localparam int RCW = $clog2(RST_CYCLES+1);
    typedef enum logic [1:0] {RST_MON, IDLE, STREAM} state_t;
    state_t state, state_n;
    logic [RCW-1:0]   rst_cnt, rst_cnt_n;
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count, push_cnt;
    logic [SYM_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_addr [NUM_EVT];
    logic [NUM_EVT-1:0] wr_en;
    logic             pop, mon_reset_n, do_push;
    assign occupancy = count;
    assign evt_ready = (CW'(DEPTH) - count) >= CW'(NUM_EVT);
    assign do_push   = evt_ready && !flush;
    // Valid lanes are packed into consecutive slots, lowest lane first
    always_comb begin
        push_cnt = '0;
        for (int i = 0; i < NUM_EVT; i++) begin
            wr_en[i]   = do_push && evt_valid[i];
            wr_addr[i] = wr_ptr + push_cnt[AW-1:0];
            push_cnt   = push_cnt + CW'(wr_en[i]);
        end
    end
    always_comb begin
        state_n     = state;
        rst_cnt_n   = rst_cnt;
        mon_reset_n = 1'b0;
        pop         = 1'b0;
        if (flush) begin
            state_n     = RST_MON;
            rst_cnt_n   = '0;
            mon_reset_n = 1'b1;
        end else begin
            case (state)
                RST_MON: begin
                    if (rst_cnt == RCW'(RST_CYCLES-1)) begin
                        state_n = enable ? STREAM : IDLE;
                    end else begin
                        rst_cnt_n   = rst_cnt + 1'b1;
                        mon_reset_n = 1'b1;
                    end
                end
                IDLE:    state_n = enable ? STREAM : IDLE;
                STREAM: begin
                    state_n = enable ? STREAM : IDLE;
                    pop     = enable && (count != '0);
                end
                default: state_n = RST_MON;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_EVT; i++)
            if (wr_en[i]) mem[wr_addr[i]] <= evt_sym[i*SYM_W +: SYM_W];
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= RST_MON;
            rst_cnt   <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            symbols   <= '0;
            run       <= 1'b0;
            mon_reset <= 1'b1;
            overflow  <= 1'b0;
        end else begin
            state     <= state_n;
            rst_cnt   <= rst_cnt_n;
            mon_reset <= mon_reset_n;
            run       <= pop;
            if (pop) symbols <= mem[rd_ptr];
            if (flush) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
                overflow <= 1'b0;
            end else begin
                wr_ptr <= wr_ptr + push_cnt[AW-1:0];
                rd_ptr <= rd_ptr + AW'(pop);
                count  <= count + push_cnt - CW'(pop);
                if (|evt_valid && !evt_ready) overflow <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_rm_symbol_feeder.sv
// tb_rm_symbol_feeder: queue-based reference model driving directed and random traffic.
module tb_rm_symbol_feeder;
    localparam int M_RST = 0, M_IDLE = 1, M_STREAM = 2;
    logic        clk = 1'b0, reset = 1'b1, enable = 1'b0, flush = 1'b0;
    logic [1:0]  evt_valid = '0;
    logic [15:0] evt_sym = '0;
    logic        evt_ready, run, mon_reset, overflow;
    logic [7:0]  symbols;
    logic [3:0]  occupancy;
    int checks = 0, errors = 0;
    int q[$];
    int mode, rcnt, m_sym, m_run, m_mrst, m_ovf;

    rm_symbol_feeder dut (
        .clk(clk), .reset(reset), .evt_valid(evt_valid), .evt_sym(evt_sym),
        .evt_ready(evt_ready), .enable(enable), .flush(flush), .symbols(symbols),
        .run(run), .mon_reset(mon_reset), .overflow(overflow), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        mode = M_RST; rcnt = 0; m_sym = 0; m_run = 0; m_mrst = 1; m_ovf = 0;
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".run"}, run, m_run);
        if (m_run != 0) chk({tag, ".sym"}, symbols, m_sym);
        chk({tag, ".mrst"}, mon_reset, m_mrst);
        chk({tag, ".ovf"}, overflow, m_ovf);
        chk({tag, ".occ"}, occupancy, q.size());
    endtask

    task automatic cyc(input string tag, input logic en, input logic fl,
                       input logic [1:0] v, input logic [15:0] s);
        logic rdy;
        enable = en; flush = fl; evt_valid = v; evt_sym = s;
        rdy = (8 - q.size()) >= 2;
        chk({tag, ".rdy"}, evt_ready, rdy);
        @(posedge clk);
        if (fl) begin
            q.delete(); m_ovf = 0; mode = M_RST; rcnt = 0; m_mrst = 1; m_run = 0;
        end else begin
            m_run = 0; m_mrst = 0;
            if (mode == M_RST) begin
                rcnt++;
                if (rcnt == 2) mode = en ? M_STREAM : M_IDLE;
                else m_mrst = 1;
            end else if (mode == M_IDLE) begin
                if (en) mode = M_STREAM;
            end else if (!en) mode = M_IDLE;
            else if (q.size() > 0) begin
                m_sym = q.pop_front(); m_run = 1;
            end
            if (rdy) begin
                for (int i = 0; i < 2; i++) if (v[i]) q.push_back(int'(s[i*8 +: 8]));
            end else if (v != 0) m_ovf = 1;
        end
        #1;
        chk_all(tag);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset");
        chk("reset.sym0", symbols, 0);
        chk("reset.rdy", evt_ready, 1);
        @(negedge clk) reset = 1'b0;
        // mon_reset sequencing with an empty FIFO
        repeat (4) cyc("t1", 1, 0, 2'b00, 16'h0);
        // ordering across lanes
        cyc("t2a", 1, 0, 2'b11, 16'h2211);
        cyc("t2b", 1, 0, 2'b01, 16'h0033);
        repeat (4) cyc("t2c", 1, 0, 2'b00, 16'h0);
        // fill, overflow, drain
        cyc("t3i", 0, 0, 2'b00, 16'h0);
        for (int i = 0; i < 4; i++) cyc("t3f", 0, 0, 2'b11, 16'($urandom));
        chk("t3.full", occupancy, 8);
        cyc("t3o", 0, 0, 2'b01, 16'h00AA);
        chk("t3.ovf", overflow, 1);
        repeat (10) cyc("t3d", 1, 0, 2'b00, 16'h0);
        // steady push/pop across pointer wrap
        for (int i = 0; i < 20; i++) cyc("t4", 1, 0, 2'b01, 16'($urandom));
        repeat (3) cyc("t4d", 1, 0, 2'b00, 16'h0);
        // flush with buffered data
        cyc("t5i", 0, 0, 2'b11, 16'($urandom));
        cyc("t5i", 0, 0, 2'b11, 16'($urandom));
        cyc("t5i", 0, 0, 2'b10, 16'($urandom));
        chk("t5.occ5", occupancy, 5);
        cyc("t5f", 1, 1, 2'b11, 16'($urandom));
        repeat (4) cyc("t5p", 1, 0, 2'b00, 16'h0);
        cyc("t5n", 1, 0, 2'b01, 16'h0077);
        repeat (2) cyc("t5n", 1, 0, 2'b00, 16'h0);
        // random traffic
        for (int i = 0; i < 300; i++)
            cyc("rnd", $urandom_range(0, 7) != 0, $urandom_range(0, 40) == 0,
                2'($urandom), 16'($urandom));
        // async reset between edges
        for (int i = 0; i < 4; i++) cyc("t6p", 1, 0, 2'b11, 16'($urandom));
        evt_valid = 2'b00; flush = 1'b0;
        #2 reset = 1'b1;
        #1;
        model_reset();
        chk_all("t6");
        chk("t6.sym0", symbols, 0);
        @(negedge clk) reset = 1'b0;
        repeat (4) cyc("t6r", 1, 0, 2'b00, 16'h0);
        cyc("t6r", 1, 0, 2'b11, 16'h5544);
        repeat (3) cyc("t6r", 1, 0, 2'b00, 16'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
